// File: rtl/chacha_stream_ctrl.sv
// AXI-Stream front end for chacha_many: packs 32-bit words into one group,
// kicks the core, waits for a fresh result and streams it back out.
module chacha_stream_ctrl #(
    parameter int NUMBER_OF_BLOCKS = 1,
    parameter int TOTAL_BIT_WIDTH  = NUMBER_OF_BLOCKS*512
) (
    input  logic                       clk,
    input  logic                       aresetn,
    input  logic [31:0]                s_axis_tdata,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic                       s_axis_tlast,
    output logic [31:0]                m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic [TOTAL_BIT_WIDTH-1:0] chacha_data_in,
    output logic                       chacha_next_block,
    input  logic [TOTAL_BIT_WIDTH-1:0] chacha_data_out,
    input  logic                       chacha_data_valid,
    output logic [31:0]                groups_done
);

    localparam int NUMBER_OF_WORDS = NUMBER_OF_BLOCKS*16;
    localparam int CW = $clog2(NUMBER_OF_WORDS+1);
    localparam int IW = $clog2(TOTAL_BIT_WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUMBER_OF_WORDS-1);

    typedef enum logic [2:0] {
        INIT,
        FILL,
        KICK,
        WAIT_DROP,
        WAIT_VALID,
        DRAIN
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]              fill_cnt;
    logic [CW-1:0]              word_count;
    logic [CW-1:0]              rd_idx;
    logic                       last_flag;
    logic [TOTAL_BIT_WIDTH-1:0] out_buf;
    logic [IW-1:0]              wr_pos;
    logic [IW-1:0]              rd_pos;
    logic                       in_hs;
    logic                       out_hs;
    logic                       fill_done;
    logic                       drain_done;

    assign wr_pos     = IW'({fill_cnt, 5'd0});
    assign rd_pos     = IW'({rd_idx, 5'd0});
    assign in_hs      = (state == FILL) && s_axis_tvalid;
    assign out_hs     = (state == DRAIN) && m_axis_tready;
    assign fill_done  = in_hs && ((fill_cnt == LAST_IDX) || s_axis_tlast);
    assign drain_done = out_hs && (rd_idx == word_count - 1'b1);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next        = state;
        s_axis_tready     = 1'b0;
        m_axis_tvalid     = 1'b0;
        m_axis_tlast      = 1'b0;
        m_axis_tdata      = '0;
        chacha_next_block = 1'b0;
        unique case (state)
            INIT: state_next = FILL;
            FILL: begin
                s_axis_tready = 1'b1;
                if (fill_done) state_next = KICK;
            end
            KICK: begin
                chacha_next_block = 1'b1;
                state_next        = WAIT_DROP;
            end
            // A valid still high from the previous group must fall before
            // a result is trusted.
            WAIT_DROP:  if (!chacha_data_valid) state_next = WAIT_VALID;
            WAIT_VALID: if (chacha_data_valid)  state_next = DRAIN;
            DRAIN: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = out_buf[rd_pos +: 32];
                m_axis_tlast  = last_flag && (rd_idx == word_count - 1'b1);
                if (drain_done) state_next = FILL;
            end
            default: state_next = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            chacha_data_in <= '0;
            out_buf        <= '0;
            fill_cnt       <= '0;
            word_count     <= '0;
            rd_idx         <= '0;
            last_flag      <= 1'b0;
            groups_done    <= '0;
        end else begin
            unique case (state)
                FILL: begin
                    if (in_hs) begin
                        chacha_data_in[wr_pos +: 32] <= s_axis_tdata;
                        if (fill_done) begin
                            word_count <= fill_cnt + 1'b1;
                            last_flag  <= s_axis_tlast;
                            fill_cnt   <= '0;
                        end else begin
                            fill_cnt <= fill_cnt + 1'b1;
                        end
                    end
                end
                WAIT_VALID: begin
                    if (chacha_data_valid) begin
                        out_buf <= chacha_data_out;
                        rd_idx  <= '0;
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        // Clearing here zero-pads the next short group.
                        groups_done    <= groups_done + 32'd1;
                        chacha_data_in <= '0;
                        rd_idx         <= '0;
                        word_count     <= '0;
                        last_flag      <= 1'b0;
                    end else if (out_hs) begin
                        rd_idx <= rd_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chacha_stream_ctrl.sv
// Bench for chacha_stream_ctrl: packets are split into groups by a queue
// model, the core is emulated inline, and each output word is compared.
module tb_chacha_stream_ctrl;

    localparam int NB = 1;
    localparam int NW = NB*16;
    localparam int TW = NB*512;

    logic          clk = 1'b0;
    logic          aresetn = 1'b0;
    logic [31:0]   s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic [31:0]   m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          m_axis_tlast;
    logic [TW-1:0] chacha_data_in;
    logic          chacha_next_block;
    logic [TW-1:0] chacha_data_out = '0;
    logic          chacha_data_valid = 1'b0;
    logic [31:0]   groups_done;

    int errors = 0;
    int checks = 0;
    int pulses = 0;
    int exp_gd = 0;

    chacha_stream_ctrl #(.NUMBER_OF_BLOCKS(NB)) dut (
        .clk               (clk),
        .aresetn           (aresetn),
        .s_axis_tdata      (s_axis_tdata),
        .s_axis_tvalid     (s_axis_tvalid),
        .s_axis_tready     (s_axis_tready),
        .s_axis_tlast      (s_axis_tlast),
        .m_axis_tdata      (m_axis_tdata),
        .m_axis_tvalid     (m_axis_tvalid),
        .m_axis_tready     (m_axis_tready),
        .m_axis_tlast      (m_axis_tlast),
        .chacha_data_in    (chacha_data_in),
        .chacha_next_block (chacha_next_block),
        .chacha_data_out   (chacha_data_out),
        .chacha_data_valid (chacha_data_valid),
        .groups_done       (groups_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (aresetn && chacha_next_block) pulses++;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, chacha_next_block} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000",
                     {s_axis_tready, m_axis_tvalid, m_axis_tlast, chacha_next_block});
        end
        checks++;
        if (m_axis_tdata !== 32'd0 || groups_done !== 32'd0 || chacha_data_in !== '0) begin
            errors++;
            $display("FAIL reset_data: got tdata=%h gd=%h expected 0", m_axis_tdata, groups_done);
        end
        repeat (3) step;
        aresetn = 1'b1;
        checks++;
        if (s_axis_tready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 0", s_axis_tready);
        end
        step;
        checks++;
        if (s_axis_tready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_release: got %b expected 1", s_axis_tready);
        end
    endtask

    // abort_at: 0 none, 1 reset in WAIT_VALID, 2 reset after 5 drained words.
    task automatic run_packet(input int n, input bit fixed, input bit stale,
                              input bit bp, input int abort_at);
        logic [31:0]   words[$];
        logic [TW-1:0] exp_in;
        logic [TW-1:0] resp;
        int            pos;
        int            wc;
        int            p0;
        int            ngroups;
        int            cnt;
        int            i;
        int            cyc;
        bit            r;
        bit            last_grp;
        bit [3:0]      pat;

        pat = 4'b1001;
        for (int k = 0; k < n; k++) words.push_back(fixed ? 32'(k + 1) : $urandom);
        ngroups = (n + NW - 1) / NW;
        p0 = pulses;
        pos = 0;
        for (int g = 0; g < ngroups; g++) begin
            wc = (n - pos < NW) ? (n - pos) : NW;
            last_grp = (pos + wc == n);
            exp_in = '0;
            for (int k = 0; k < wc; k++) exp_in[32*k +: 32] = words[pos + k];

            for (int k = 0; k < wc; k++) begin
                repeat ($urandom_range(0, 2)) step;
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = words[pos + k];
                s_axis_tlast  = (pos + k == n - 1);
                cnt = 0;
                while (!s_axis_tready && cnt < 100) begin
                    step;
                    cnt++;
                end
                checks++;
                if (cnt >= 100) begin
                    errors++;
                    $display("FAIL fill_timeout: got ready=0 expected ready=1 within 100 cycles");
                end
                step;
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
            end

            checks++;
            if (chacha_next_block !== 1'b1 || s_axis_tready !== 1'b0) begin
                errors++;
                $display("FAIL kick: got next=%b ready=%b expected next=1 ready=0",
                         chacha_next_block, s_axis_tready);
            end
            checks++;
            if (chacha_data_in !== exp_in) begin
                errors++;
                $display("FAIL data_in: got %h expected %h", chacha_data_in, exp_in);
            end

            if (!stale) chacha_data_valid = 1'b0;
            step;
            checks++;
            if (chacha_next_block !== 1'b0 || m_axis_tvalid !== 1'b0) begin
                errors++;
                $display("FAIL kick_single: got next=%b tvalid=%b expected 0 0",
                         chacha_next_block, m_axis_tvalid);
            end
            if (stale) begin
                chacha_data_valid = 1'b1;
                repeat (3) begin
                    step;
                    checks++;
                    if (m_axis_tvalid !== 1'b0) begin
                        errors++;
                        $display("FAIL stale_capture: got tvalid=%b expected 0", m_axis_tvalid);
                    end
                end
                chacha_data_valid = 1'b0;
                repeat (5) step;
            end else begin
                repeat (1 + $urandom_range(0, 2)) step;
            end

            if (abort_at == 1) begin
                aresetn = 1'b0;
                #1;
                checks++;
                if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, chacha_next_block} !== 4'b0 ||
                    m_axis_tdata !== 32'd0 || groups_done !== 32'd0 || chacha_data_in !== '0) begin
                    errors++;
                    $display("FAIL abort_wait: got ctrl=%b gd=%h expected all zero",
                             {s_axis_tready, m_axis_tvalid, m_axis_tlast, chacha_next_block}, groups_done);
                end
                step;
                aresetn = 1'b1;
                exp_gd = 0;
                step;
                checks++;
                if (s_axis_tready !== 1'b1) begin
                    errors++;
                    $display("FAIL abort_wait_ready: got %b expected 1", s_axis_tready);
                end
                return;
            end

            for (int k = 0; k < NW; k++) resp[32*k +: 32] = $urandom;
            chacha_data_out   = resp;
            chacha_data_valid = 1'b1;
            checks++;
            if (m_axis_tvalid !== 1'b0) begin
                errors++;
                $display("FAIL early_tvalid: got %b expected 0", m_axis_tvalid);
            end
            step;
            checks++;
            if (m_axis_tvalid !== 1'b1 || chacha_data_in !== exp_in) begin
                errors++;
                $display("FAIL capture: got tvalid=%b data_in_ok=%b expected 1 1",
                         m_axis_tvalid, chacha_data_in === exp_in);
            end
            // A real core may change its output bus while the old result drains.
            chacha_data_out = '1;

            i = 0;
            cyc = 0;
            while (i < wc && cyc < 200) begin
                if (abort_at == 2 && i == 5) begin
                    aresetn = 1'b0;
                    #1;
                    checks++;
                    if ({s_axis_tready, m_axis_tvalid, m_axis_tlast, chacha_next_block} !== 4'b0 ||
                        m_axis_tdata !== 32'd0 || groups_done !== 32'd0 || chacha_data_in !== '0) begin
                        errors++;
                        $display("FAIL abort_drain: got ctrl=%b tdata=%h expected all zero",
                                 {s_axis_tready, m_axis_tvalid, m_axis_tlast, chacha_next_block}, m_axis_tdata);
                    end
                    m_axis_tready = 1'b0;
                    step;
                    aresetn = 1'b1;
                    exp_gd = 0;
                    step;
                    checks++;
                    if (s_axis_tready !== 1'b1) begin
                        errors++;
                        $display("FAIL abort_drain_ready: got %b expected 1", s_axis_tready);
                    end
                    return;
                end
                r = bp ? pat[cyc % 4] : 1'($urandom_range(0, 1));
                m_axis_tready = r;
                checks++;
                if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== resp[32*i +: 32] ||
                    m_axis_tlast !== (last_grp && i == wc - 1) || s_axis_tready !== 1'b0) begin
                    errors++;
                    $display("FAIL drain_word%0d: got v=%b d=%h l=%b rdy=%b expected v=1 d=%h l=%b rdy=0",
                             i, m_axis_tvalid, m_axis_tdata, m_axis_tlast, s_axis_tready,
                             resp[32*i +: 32], last_grp && i == wc - 1);
                end
                step;
                cyc++;
                if (r) i++;
            end
            m_axis_tready = 1'b0;
            checks++;
            if (i < wc) begin
                errors++;
                $display("FAIL drain_timeout: got %0d words expected %0d", i, wc);
            end
            exp_gd++;
            checks++;
            if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b1 ||
                groups_done !== 32'(exp_gd) || chacha_data_in !== '0) begin
                errors++;
                $display("FAIL group_end: got v=%b rdy=%b gd=%0d expected v=0 rdy=1 gd=%0d cleared",
                         m_axis_tvalid, s_axis_tready, groups_done, exp_gd);
            end
            pos += wc;
        end
        checks++;
        if (pulses - p0 != ngroups) begin
            errors++;
            $display("FAIL kick_count: got %0d expected %0d", pulses - p0, ngroups);
        end
    endtask

    task automatic test_full_group;     run_packet(16, 1'b1, 1'b0, 1'b0, 0); endtask
    task automatic test_short_packet;   run_packet(3,  1'b0, 1'b0, 1'b0, 0); endtask
    task automatic test_split_packet;   run_packet(20, 1'b0, 1'b0, 1'b0, 0); endtask
    task automatic test_stale_valid;    run_packet(16, 1'b0, 1'b1, 1'b0, 0); endtask
    task automatic test_backpressure;   run_packet(16, 1'b0, 1'b0, 1'b1, 0); endtask

    task automatic test_abort;
        run_packet(16, 1'b0, 1'b0, 1'b0, 1);
        run_packet(16, 1'b0, 1'b0, 1'b0, 0);
        run_packet(16, 1'b0, 1'b0, 1'b0, 2);
        run_packet(16, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic test_back_to_back;
        for (int t = 0; t < 6; t++)
            run_packet($urandom_range(1, 40), 1'b0, 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 0);
    endtask

    initial begin
        test_reset;
        test_full_group;
        test_short_packet;
        test_split_packet;
        test_stale_valid;
        test_backpressure;
        test_abort;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish before 2ms");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/chacha_stream_ctrl.md
# chacha_stream_ctrl

AXI-Stream front end that drives `chacha_many` from the opposite side. It packs incoming 32-bit stream words into one `NUMBER_OF_BLOCKS*512`-bit group and presents it on `chacha_data_in`. It then pulses `chacha_next_block`, waits for the new keystream-combined result, latches `chacha_data_out` and streams it back out word by word with correct `tlast`. It is the only block that issues `chacha_next_block` in the datapath.

## Interface
- `NUMBER_OF_BLOCKS`, default 1: ChaCha blocks per group. Must match the attached `chacha_many`.
- `TOTAL_BIT_WIDTH`, default `NUMBER_OF_BLOCKS*512`: group width. Derived; do not override.
- `NUMBER_OF_WORDS` (localparam), `NUMBER_OF_BLOCKS*16`: words per group.

Ports:
- `clk` in 1: single clock for all logic.
- `aresetn` in 1: reset, asynchronous and active-low.
- `s_axis_tdata` in 32: input word.
- `s_axis_tvalid` in 1: input valid.
- `s_axis_tready` out 1: input ready.
- `s_axis_tlast` in 1: final word of a packet.
- `m_axis_tdata` out 32: output word.
- `m_axis_tvalid` out 1: output valid.
- `m_axis_tready` in 1: output ready.
- `m_axis_tlast` out 1: final word of a packet.
- `chacha_data_in` out `TOTAL_BIT_WIDTH`: packed group to `chacha_many`.
- `chacha_next_block` out 1: one-cycle start pulse to `chacha_many`.
- `chacha_data_out` in `TOTAL_BIT_WIDTH`: result from `chacha_many`.
- `chacha_data_valid` in 1: result valid from `chacha_many`.
- `groups_done` out 32: count of fully drained groups, wraps at 2^32.

## Operation
- States: INIT, FILL, KICK, WAIT_DROP, WAIT_VALID, DRAIN.
- Asynchronous reset puts the state in INIT and clears all registers and outputs to 0.
- INIT → FILL on the first clock edge with `aresetn` high.
- FILL
  - `s_axis_tready`=1. Each accepted word (tvalid&tready) number k is written to `chacha_data_in[32k +: 32]`, k = 0..NUMBER_OF_WORDS-1. No byte swap in this block.
  - The word counter has width `$clog2(NUMBER_OF_WORDS+1)`.
  - Go to KICK when word NUMBER_OF_WORDS-1 is accepted, or when a word with `s_axis_tlast`=1 is accepted.
  - Record `word_count` (1..NUMBER_OF_WORDS) and `last_flag` (the accepted tlast).
  - Words not received in a short group stay 0, because the buffer is cleared on entry to FILL.
- KICK: `chacha_next_block`=1 for exactly this one cycle, then WAIT_DROP.
- WAIT_DROP: stay until `chacha_data_valid`=0 is sampled, then WAIT_VALID. This rejects a stale valid left over from the previous group.
- WAIT_VALID: on `chacha_data_valid`=1, register `chacha_data_out` into the output buffer and go to DRAIN.
- DRAIN
  - `m_axis_tvalid`=1, `m_axis_tdata` = output word i, starting at i=0.
  - Advance i on each handshake.
  - `m_axis_tlast` = (i == word_count-1) && last_flag.
  - After the handshake on word word_count-1: increment `groups_done`, clear the input buffer and counters, go to FILL.
- `chacha_data_in` stays stable from KICK until DRAIN exits.
- Only words 0..word_count-1 are emitted. Padding results are discarded.
- Packets longer than one group split across groups. tlast appears only on the real final word.

## Timing
- Reset values: `s_axis_tready`=0, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `chacha_next_block`=0, `chacha_data_in`=0, `groups_done`=0.
- `s_axis_tready` is decoded from state (FILL only). It first rises one cycle after reset release.
- Last input acceptance at edge n → `chacha_next_block` high in cycle n+1. `s_axis_tready` is low from cycle n+1.
- `chacha_data_valid` sampled high at edge m → `m_axis_tvalid` high in cycle m+1. Minimum latency from valid to first output is 1 cycle.
- AXI-Stream rules: while `m_axis_tvalid`=1 and `m_axis_tready`=0, `m_axis_tdata`/`m_axis_tlast` hold. `m_axis_tvalid` never drops before the handshake.
- The last output handshake at edge p → `s_axis_tready`=1 in cycle p+1. `m_axis_tvalid`=0 in cycle p+1.
- There is no input/output overlap; throughput is one group per round trip.
- `aresetn` low mid-operation, in any state, immediately aborts: outputs go to reset values and the partial group is lost.
- `chacha_data_valid` is ignored outside WAIT_DROP/WAIT_VALID.

## Test plan
- Full group, `NUMBER_OF_BLOCKS`=1, words 0x00000001..0x00000010, tlast on the 16th:
  - `chacha_data_in[31:0]`=0x00000001 and `[511:480]`=0x00000010.
  - One `chacha_next_block` pulse.
  - 16 outputs equal to the `chacha_data_out` words; tlast on the 16th only; `groups_done`=1.
- Short packet of 3 words with tlast on the 3rd:
  - `chacha_data_in[511:96]`=0.
  - Exactly 3 output words; tlast on word 2.
- Packet of 20 words:
  - Group 1 emits 16 words with no tlast.
  - Group 2 emits 4 words with tlast on the 4th.
  - Two `chacha_next_block` pulses; `groups_done`=2.
- Stale valid: hold `chacha_data_valid`=1 through KICK, drop it for 5 cycles, then raise it → capture happens only after the rise, with new data.
- Output backpressure: `m_axis_tready` toggles 1,0,0,1 → each word is held stable while tready=0; no loss or duplication; `s_axis_tready` stays 0 until the last handshake.
- Assert `aresetn`=0 in WAIT_VALID and again mid-DRAIN:
  - All outputs are 0 immediately.
  - After release, `s_axis_tready`=1 one cycle later and a fresh 16-word group completes correctly.
